rv32i_multiplier_arbiter: RTL and testbench

RV32I_MULTIPLIER_ARBITER -- requirements
Module: rv32I_multiplier_arbiter

---
 rtl/rv32i_multiplier_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rv32i_multiplier_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multiplier_arbiter.sv
// Round-robin arbiter sharing one 16x16 multiplier IP between two requesters.
// A transaction walks IDLE -> ISSUE -> RESP -> DRAIN; every output is a flop.
// An ISSUE that sees no IP result within TIMEOUT_CYCLES cycles completes with
// an error strobe. A requester that abandons its request still occupies the IP
// until completion; its strobe is then suppressed.
module rv32i_multiplier_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_en,
  input  logic [15:0] i_req0_operand_one,
  input  logic [15:0] i_req0_operand_two,
  output logic        o_req0_valid,
  output logic [31:0] o_req0_result,
  output logic        o_req0_error,
  input  logic        i_req1_en,
  input  logic [15:0] i_req1_operand_one,
  input  logic [15:0] i_req1_operand_two,
  output logic        o_req1_valid,
  output logic [31:0] o_req1_result,
  output logic        o_req1_error,
  output logic        o_multiplier_en,
  output logic [15:0] o_multiplier_operand_one,
  output logic [15:0] o_multiplier_operand_two,
  input  logic        i_multiplier_valid,
  input  logic [31:0] i_multiplier_result
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;        // port granted by the last completed transaction
  logic          grant_q, grant_d;      // port owning the current transaction
  logic          abandon_q, abandon_d;  // owner dropped its request during ISSUE
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_en_q, mul_en_d;
  logic [15:0]   op_one_q, op_one_d;
  logic [15:0]   op_two_q, op_two_d;
  logic          r0_valid_q, r0_valid_d;
  logic [31:0]   r0_result_q, r0_result_d;
  logic          r0_error_q, r0_error_d;
  logic          r1_valid_q, r1_valid_d;
  logic [31:0]   r1_result_q, r1_result_d;
  logic          r1_error_q, r1_error_d;

  logic          win_one;
  logic          done;
  logic          aband;
  logic [31:0]   fin_result;
  logic          fin_error;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    abandon_d   = abandon_q;
    cnt_d       = cnt_q;
    mul_en_d    = mul_en_q;
    op_one_d    = op_one_q;
    op_two_d    = op_two_q;
    r0_valid_d  = 1'b0;
    r0_result_d = '0;
    r0_error_d  = 1'b0;
    r1_valid_d  = 1'b0;
    r1_result_d = '0;
    r1_error_d  = 1'b0;
    win_one     = 1'b0;
    done        = 1'b0;
    aband       = 1'b0;
    fin_result  = '0;
    fin_error   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req0_en || i_req1_en) begin
          // On a tie the port not granted last wins.
          win_one   = i_req1_en && (!i_req0_en || !last_q);
          grant_d   = win_one;
          op_one_d  = win_one ? i_req1_operand_one : i_req0_operand_one;
          op_two_d  = win_one ? i_req1_operand_two : i_req0_operand_two;
          mul_en_d  = 1'b1;
          cnt_d     = '0;
          abandon_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        aband     = abandon_q || !(grant_q ? i_req1_en : i_req0_en);
        abandon_d = aband;
        if (i_multiplier_valid) begin
          done       = 1'b1;
          fin_result = i_multiplier_result;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          fin_error = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          mul_en_d = 1'b0;
          last_d   = grant_q;
          state_d  = S_RESP;
          if (!aband) begin
            if (grant_q) begin
              r1_valid_d  = 1'b1;
              r1_result_d = fin_result;
              r1_error_d  = fin_error;
            end else begin
              r0_valid_d  = 1'b1;
              r0_result_d = fin_result;
              r0_error_d  = fin_error;
            end
          end
        end
      end
      S_RESP:  state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      abandon_q   <= 1'b0;
      cnt_q       <= '0;
      mul_en_q    <= 1'b0;
      op_one_q    <= '0;
      op_two_q    <= '0;
      r0_valid_q  <= 1'b0;
      r0_result_q <= '0;
      r0_error_q  <= 1'b0;
      r1_valid_q  <= 1'b0;
      r1_result_q <= '0;
      r1_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      abandon_q   <= abandon_d;
      cnt_q       <= cnt_d;
      mul_en_q    <= mul_en_d;
      op_one_q    <= op_one_d;
      op_two_q    <= op_two_d;
      r0_valid_q  <= r0_valid_d;
      r0_result_q <= r0_result_d;
      r0_error_q  <= r0_error_d;
      r1_valid_q  <= r1_valid_d;
      r1_result_q <= r1_result_d;
      r1_error_q  <= r1_error_d;
    end
  end

  assign o_multiplier_en          = mul_en_q;
  assign o_multiplier_operand_one = op_one_q;
  assign o_multiplier_operand_two = op_two_q;
  assign o_req0_valid             = r0_valid_q;
  assign o_req0_result            = r0_result_q;
  assign o_req0_error             = r0_error_q;
  assign o_req1_valid             = r1_valid_q;
  assign o_req1_result            = r1_result_q;
  assign o_req1_error             = r1_error_q;

endmodule

// File: tb/tb_rv32i_multiplier_arbiter.sv
// Directed bench for rv32i_multiplier_arbiter; the bench plays the multiplier IP.
module tb_rv32i_multiplier_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_en, i_req1_en;
  logic [15:0] i_req0_operand_one, i_req0_operand_two;
  logic [15:0] i_req1_operand_one, i_req1_operand_two;
  logic        o_req0_valid, o_req0_error, o_req1_valid, o_req1_error;
  logic [31:0] o_req0_result, o_req1_result;
  logic        o_multiplier_en;
  logic [15:0] o_multiplier_operand_one, o_multiplier_operand_two;
  logic        i_multiplier_valid;
  logic [31:0] i_multiplier_result;

  int checks = 0;
  int failures = 0;
  int n;

  rv32i_multiplier_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_en(i_req0_en), .i_req0_operand_one(i_req0_operand_one),
    .i_req0_operand_two(i_req0_operand_two),
    .o_req0_valid(o_req0_valid), .o_req0_result(o_req0_result), .o_req0_error(o_req0_error),
    .i_req1_en(i_req1_en), .i_req1_operand_one(i_req1_operand_one),
    .i_req1_operand_two(i_req1_operand_two),
    .o_req1_valid(o_req1_valid), .o_req1_result(o_req1_result), .o_req1_error(o_req1_error),
    .o_multiplier_en(o_multiplier_en),
    .o_multiplier_operand_one(o_multiplier_operand_one),
    .o_multiplier_operand_two(o_multiplier_operand_two),
    .i_multiplier_valid(i_multiplier_valid), .i_multiplier_result(i_multiplier_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps until o_multiplier_en rises (bounded); n = edges taken.
  task automatic wait_en(input string tag, output int cnt);
    cnt = 0;
    while (!o_multiplier_en && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_en_seen"}, {31'd0, o_multiplier_en}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b1;
    i_req0_en = 1'b0; i_req1_en = 1'b0;
    i_req0_operand_one = '0; i_req0_operand_two = '0;
    i_req1_operand_one = '0; i_req1_operand_two = '0;
    i_multiplier_valid = 1'b0; i_multiplier_result = '0;

    // Reset state
    step(); step();
    chk("rst_en", {31'd0, o_multiplier_en}, 32'd0);
    chk("rst_v0", {31'd0, o_req0_valid}, 32'd0);
    chk("rst_v1", {31'd0, o_req1_valid}, 32'd0);
    chk("rst_r0", o_req0_result, 32'd0);
    chk("rst_r1", o_req1_result, 32'd0);
    chk("rst_op1", {16'd0, o_multiplier_operand_one}, 32'd0);

    // Single req0, 3*5, IP answers 4 cycles after en
    i_rst = 1'b0;
    i_req0_en = 1'b1; i_req0_operand_one = 16'h0003; i_req0_operand_two = 16'h0005;
    step();
    chk("t1_en", {31'd0, o_multiplier_en}, 32'd1);
    chk("t1_op1", {16'd0, o_multiplier_operand_one}, 32'h3);
    chk("t1_op2", {16'd0, o_multiplier_operand_two}, 32'h5);
    step(); step(); step();
    chk("t1_en_hold", {31'd0, o_multiplier_en}, 32'd1);
    chk("t1_no_early_v", {31'd0, o_req0_valid}, 32'd0);
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h0000000F;
    step();
    i_multiplier_valid = 1'b0; i_req0_en = 1'b0;
    chk("t1_v0", {31'd0, o_req0_valid}, 32'd1);
    chk("t1_r0", o_req0_result, 32'h0000000F);
    chk("t1_e0", {31'd0, o_req0_error}, 32'd0);
    chk("t1_en_low", {31'd0, o_multiplier_en}, 32'd0);
    chk("t1_v1", {31'd0, o_req1_valid}, 32'd0);
    step();
    chk("t1_v0_pulse", {31'd0, o_req0_valid}, 32'd0);
    chk("t1_r0_clear", o_req0_result, 32'd0);
    step(); step();

    // Tie after a port-0 grant goes to port 1; reset mid-ISSUE, late IP valid
    i_req0_en = 1'b1; i_req0_operand_one = 16'h0002; i_req0_operand_two = 16'h0003;
    i_req1_en = 1'b1; i_req1_operand_one = 16'h0004; i_req1_operand_two = 16'h0005;
    step();
    chk("t5_grant1", {16'd0, o_multiplier_operand_one}, 32'h4);
    step();
    i_rst = 1'b1;
    step();
    chk("t5_rst_en", {31'd0, o_multiplier_en}, 32'd0);
    chk("t5_rst_op", {16'd0, o_multiplier_operand_one}, 32'd0);
    i_rst = 1'b0;
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h0000BEEF;
    step();
    i_multiplier_valid = 1'b0;
    chk("t5_v0", {31'd0, o_req0_valid}, 32'd0);
    chk("t5_v1", {31'd0, o_req1_valid}, 32'd0);
    chk("t5_r1", o_req1_result, 32'd0);
    chk("t5_en", {31'd0, o_multiplier_en}, 32'd1);
    chk("t5_tie_port0", {16'd0, o_multiplier_operand_one}, 32'h2);

    // Both requesting continuously, IP latency 2: grants 0,1,0,1
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_en("t2", n);
      if (i > 0) chk("t2_gap", n, 32'd3);
      chk("t2_op1", {16'd0, o_multiplier_operand_one}, (i % 2 == 1) ? 32'h4 : 32'h2);
      step();
      i_multiplier_valid = 1'b1;
      i_multiplier_result = (i % 2 == 1) ? 32'h14 : 32'h6;
      step();
      i_multiplier_valid = 1'b0;
      chk("t2_v0", {31'd0, o_req0_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_v1", {31'd0, o_req1_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("t2_res", (i % 2 == 1) ? o_req1_result : o_req0_result,
          (i % 2 == 1) ? 32'h14 : 32'h6);
    end
    i_req0_en = 1'b0; i_req1_en = 1'b0;
    step(); step(); step();
    chk("t2_idle", {31'd0, o_multiplier_en}, 32'd0);

    // req0 abandons; pending req1 served after DRAIN
    i_req0_en = 1'b1; i_req0_operand_one = 16'h0011; i_req0_operand_two = 16'h0022;
    wait_en("t4a", n);
    chk("t4_op1", {16'd0, o_multiplier_operand_one}, 32'h11);
    i_req1_en = 1'b1; i_req1_operand_one = 16'h0033; i_req1_operand_two = 16'h0044;
    step();
    i_req0_en = 1'b0;
    step();
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h00001234;
    step();
    i_multiplier_valid = 1'b0;
    chk("t4_v0_supp", {31'd0, o_req0_valid}, 32'd0);
    chk("t4_r0", o_req0_result, 32'd0);
    chk("t4_v1", {31'd0, o_req1_valid}, 32'd0);
    chk("t4_en_low", {31'd0, o_multiplier_en}, 32'd0);
    wait_en("t4b", n);
    chk("t4_gap", n, 32'd3);
    chk("t4_op1b", {16'd0, o_multiplier_operand_one}, 32'h33);
    chk("t4_op2b", {16'd0, o_multiplier_operand_two}, 32'h44);
    step();
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h00000D8C;
    step();
    i_multiplier_valid = 1'b0; i_req1_en = 1'b0;
    chk("t4_v1b", {31'd0, o_req1_valid}, 32'd1);
    chk("t4_r1b", o_req1_result, 32'h00000D8C);
    step(); step(); step();

    // req1 alone, IP silent: timeout after 64 ISSUE cycles, then req0 served
    i_req1_en = 1'b1; i_req1_operand_one = 16'h0007; i_req1_operand_two = 16'h0009;
    wait_en("t3a", n);
    chk("t3_op1", {16'd0, o_multiplier_operand_one}, 32'h7);
    n = 0;
    while (!o_req1_valid && n < 100) begin
      step();
      n++;
    end
    chk("t3_cycles", n, 32'd64);
    chk("t3_v1", {31'd0, o_req1_valid}, 32'd1);
    chk("t3_e1", {31'd0, o_req1_error}, 32'd1);
    chk("t3_r1", o_req1_result, 32'd0);
    chk("t3_v0", {31'd0, o_req0_valid}, 32'd0);
    chk("t3_en_low", {31'd0, o_multiplier_en}, 32'd0);
    i_req1_en = 1'b0;
    i_req0_en = 1'b1; i_req0_operand_one = 16'h000A; i_req0_operand_two = 16'h000B;
    wait_en("t3b", n);
    chk("t3_gap", n, 32'd3);
    chk("t3_op1b", {16'd0, o_multiplier_operand_one}, 32'hA);
    step();
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h0000006E;
    step();
    i_multiplier_valid = 1'b0; i_req0_en = 1'b0;
    chk("t3_v0b", {31'd0, o_req0_valid}, 32'd1);
    chk("t3_r0b", o_req0_result, 32'h6E);
    chk("t3_e0b", {31'd0, o_req0_error}, 32'd0);
    step(); step(); step();

    // IP valid in the same cycle the timeout would fire: valid wins
    i_req0_en = 1'b1; i_req0_operand_one = 16'h0100; i_req0_operand_two = 16'h0100;
    wait_en("t6", n);
    for (int i = 0; i < 63; i++) step();
    chk("t6_no_early_v", {31'd0, o_req0_valid}, 32'd0);
    chk("t6_en_hold", {31'd0, o_multiplier_en}, 32'd1);
    i_multiplier_valid = 1'b1; i_multiplier_result = 32'h00010000;
    step();
    i_multiplier_valid = 1'b0; i_req0_en = 1'b0;
    chk("t6_v0", {31'd0, o_req0_valid}, 32'd1);
    chk("t6_e0", {31'd0, o_req0_error}, 32'd0);
    chk("t6_r0", o_req0_result, 32'h00010000);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
